spi_frame_scheduler: RTL
========================

# spi_frame_scheduler

Round-robin scheduler that shares the SPI slave's 16-bit transmit port among `SENSORS` requesters. Each requester presents one `BITWIDTH`-bit sample. The block grants one requester at a time and serialises its sample as a header word followed by data words into the SPI slave's write interface. It retries a frame on transmit error and reports completion or drop per channel. It sits between the sensor/messaging logic and the SPI slave.

## Interface
- `SENSORS`, 4: number of requesters, 1..16.
- `BITWIDTH`, 32: sample width; must be a non-zero multiple of 16.
- `MAX_RETRY`, 3: retries after the first failed attempt before a frame is dropped, 0..15.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  SENSORS  per-channel request; held high until that channel's `done` pulse.
- `req_data`  in  SENSORS*BITWIDTH  channel i sample at bits [i*BITWIDTH +: BITWIDTH].
- `spi_tx_ready`  in  1  SPI slave can accept a word.
- `spi_tx_error`  in  1  SPI slave reports that the last word failed.
- `spi_data`  out  16  word to transmit.
- `spi_write`  out  1  one-cycle write strobe.
- `done`  out  SENSORS  one-cycle pulse on the served channel when its frame finishes.
- `done_ok`  out  1  valid with `done`: 1 = frame sent, 0 = frame dropped.
- `busy`  out  1  high in every state except IDLE.
- `drop_count`  out  8  count of dropped frames; saturates at 255.

## Operation
- Frame format:
  - `WORDS` = BITWIDTH/16 data words.
  - Word 0 is the header {8'hA5, ch[3:0], seq[3:0]}.
  - Words 1..WORDS carry the sample, most significant 16 bits first.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - If any `req` is high, the arbiter picks the first requesting channel at or after `ptr`, wrapping around.
  - The block latches that channel's sample, sets word index 0 and attempt count 0, and goes to SEND.
- SEND:
  - While `spi_tx_ready`=0, hold with `spi_data` stable and `spi_write`=0.
  - When `spi_tx_ready`=1, assert `spi_write` for one cycle with the current word, then go to WAIT.
- WAIT:
  - `spi_tx_ready` and `spi_tx_error` are ignored on the first WAIT cycle (holdoff).
  - From the second WAIT cycle on, `spi_tx_error` takes priority over `spi_tx_ready`.
  - On `spi_tx_error`=1:
    - If attempts < MAX_RETRY, increment attempts, reset the word index to 0 and go to SEND. The same header and `seq` are resent.
    - Otherwise go to DONE as a drop.
  - On `spi_tx_ready`=1: if the word index is WORDS, go to DONE as success; otherwise increment the word index and go to SEND.
- DONE, one cycle:
  - Pulse `done[ch]` and drive `done_ok`.
  - On a drop, increment `drop_count` with saturation.
  - Increment `seq` modulo 16 whether the frame was sent or dropped.
  - Set `ptr` = (ch+1) mod SENSORS, then go to IDLE.
- The latched sample is used for the whole frame. Changes to `req_data` or a `req` deassertion mid-frame have no effect on the frame in progress.
- Requests from other channels wait; none are lost while `req` stays high.

## Timing
- Reset values: `spi_data`=0, `spi_write`=0, `done`=0, `done_ok`=0, `busy`=0, `drop_count`=0, `ptr`=0, `seq`=0, state IDLE.
- Reset asserted mid-frame clears all state immediately. No `done` pulse is issued for the aborted frame.
- Latency with `spi_tx_ready` held high: `req` high at cycle 0 → header write at cycle 2.
- Each following word is written 3 cycles after the previous one.
- `done` pulses 2 cycles after the last write is accepted.
- For WORDS=2: writes at cycles 2, 5, 8; `done` at cycle 10.
- IDLE arbitrates again on the cycle after DONE, so back-to-back frames have a 1-cycle gap in IDLE.
- All outputs are registered.

## Structure
- The shared package holds:
  - the state enum;
  - `HDR_SYNC` = 8'hA5;
  - the `WORDS` localparam function;
  - the `SPI_WORD` = 16 constant.
- Sub-module `rr_arbiter` (parameter N): inputs `req` and `ptr`, outputs a one-hot `grant` and its binary index. It is combinational and instantiated once.
- Everything else is a single FSM with datapath registers: sample, word index, attempt count, `seq`, `ptr`, `drop_count`.

## Test plan
- Ch2 request, `req_data` ch2 = 32'hDEADBEEF, `spi_tx_ready` tied 1 → writes 16'hA520, 16'hDEAD, 16'hBEEF at cycles 2/5/8; `done[2]` and `done_ok`=1 at cycle 10.
- Ch0 and ch3 requesting together after reset → ch0 frame first with header 16'hA500, then ch3 with header 16'hA531; `ptr` ends at 0.
- `spi_tx_error` pulsed in WAIT after the second word → next write is header 16'hA520 again (same `seq`), followed by the full frame; `done_ok`=1.
- MAX_RETRY=3 and every attempt errors → 4 header writes, then `done_ok`=0, `drop_count`=1; the next frame carries `seq`=1.
- `spi_tx_ready` low for 10 cycles in SEND → no `spi_write`, `spi_data` stable, `busy`=1; write on the first cycle ready returns.
- `rst` driven low during a data word → all outputs return to reset values asynchronously; no `done`; after release, a pending request restarts with header `seq`=0.

Source files
------------

// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and constants for the SPI frame scheduler.
package spi_frame_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Sync byte at the top of every header word.
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    // Width of one SPI transmit word.
    localparam int SPI_WORD = 16;

    // Channel index width: the header carries a 4-bit channel number.
    localparam int CH_W = 4;

    // Number of data words that carry one sample.
    function automatic int words(input int bitwidth);
        return bitwidth / SPI_WORD;
    endfunction

endpackage

// File: rtl/spi_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import spi_frame_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] idx
);

    logic            found;
    logic [CH_W:0]   pos;

    // Walk the channels starting at ptr, wrapping at N; take the first request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (CH_W+1)'(k);
            if (pos >= (CH_W+1)'(N)) begin
                pos = pos - (CH_W+1)'(N);
            end
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (pos == (CH_W+1)'(i))) begin
                    grant[i] = 1'b1;
                    idx      = CH_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Round-robin scheduler that frames per-channel samples onto a shared SPI
// transmit port: header word, then the sample MSW first, with retry on error.
module spi_frame_scheduler
    import spi_frame_scheduler_pkg::*;
#(
    parameter int SENSORS   = 4,
    parameter int BITWIDTH  = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SENSORS-1:0]           req,
    input  logic [SENSORS*BITWIDTH-1:0]  req_data,
    input  logic                         spi_tx_ready,
    input  logic                         spi_tx_error,
    output logic [15:0]                  spi_data,
    output logic                         spi_write,
    output logic [SENSORS-1:0]           done,
    output logic                         done_ok,
    output logic                         busy,
    output logic [7:0]                   drop_count
);

    localparam int WORDS = words(BITWIDTH);
    localparam int IDX_W = $clog2(WORDS + 1);

    state_e                state_q, state_d;
    logic [BITWIDTH-1:0]   sample_q, sample_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [3:0]            att_q, att_d;
    logic [3:0]            seq_q, seq_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [7:0]            drop_q, drop_d;
    logic [15:0]           spi_data_q, spi_data_d;
    logic                  spi_write_q, spi_write_d;
    logic [SENSORS-1:0]    done_q, done_d;
    logic                  done_ok_q, done_ok_d;
    logic                  busy_q, busy_d;
    logic                  holdoff_q, holdoff_d;

    logic [SENSORS-1:0]    grant;
    logic [CH_W-1:0]       grant_idx;
    logic [BITWIDTH-1:0]   grant_sample;
    logic [15:0]           cur_word;
    logic [SENSORS-1:0]    ch_onehot;

    rr_arbiter #(.N(SENSORS)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Sample of the granted channel, selected by the one-hot grant.
    always_comb begin
        grant_sample = '0;
        for (int i = 0; i < SENSORS; i++) begin
            if (grant[i]) begin
                grant_sample = grant_sample | req_data[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Word to transmit: header at index 0, then sample words MSW first.
    always_comb begin
        cur_word = {HDR_SYNC, ch_q, seq_q};
        for (int k = 1; k <= WORDS; k++) begin
            if (widx_q == IDX_W'(k)) begin
                cur_word = sample_q[(WORDS-k)*SPI_WORD +: SPI_WORD];
            end
        end
    end

    // One-hot of the channel being served, used for the done pulse.
    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < SENSORS; i++) begin
            ch_onehot[i] = (ch_q == CH_W'(i));
        end
    end

    // Next-state and datapath update. done/done_ok are registered on the
    // transition into DONE so they are visible during the DONE cycle itself.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        ch_d        = ch_q;
        widx_d      = widx_q;
        att_d       = att_q;
        seq_d       = seq_q;
        ptr_d       = ptr_q;
        drop_d      = drop_q;
        spi_data_d  = spi_data_q;
        spi_write_d = 1'b0;
        done_d      = '0;
        done_ok_d   = 1'b0;
        holdoff_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    sample_d = grant_sample;
                    ch_d     = grant_idx;
                    widx_d   = '0;
                    att_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // spi_data only changes on a write, so it holds while stalled.
                if (spi_tx_ready) begin
                    spi_write_d = 1'b1;
                    spi_data_d  = cur_word;
                    holdoff_d   = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // First WAIT cycle ignores the slave's status lines.
                if (!holdoff_q) begin
                    if (spi_tx_error) begin
                        if (att_q < 4'(MAX_RETRY)) begin
                            att_d   = att_q + 4'd1;
                            widx_d  = '0;
                            state_d = SEND;
                        end else begin
                            done_d    = ch_onehot;
                            done_ok_d = 1'b0;
                            state_d   = DONE;
                        end
                    end else if (spi_tx_ready) begin
                        if (widx_q == IDX_W'(WORDS)) begin
                            done_d    = ch_onehot;
                            done_ok_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            widx_d  = widx_q + IDX_W'(1);
                            state_d = SEND;
                        end
                    end
                end
            end
            DONE: begin
                if (!done_ok_q && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                seq_d = seq_q + 4'd1;
                if (ch_q == CH_W'(SENSORS-1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ch_q + CH_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q    <= '0;
            ch_q        <= '0;
            widx_q      <= '0;
            att_q       <= '0;
            seq_q       <= '0;
            ptr_q       <= '0;
            drop_q      <= '0;
            spi_data_q  <= '0;
            spi_write_q <= 1'b0;
            done_q      <= '0;
            done_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
            holdoff_q   <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            ch_q        <= ch_d;
            widx_q      <= widx_d;
            att_q       <= att_d;
            seq_q       <= seq_d;
            ptr_q       <= ptr_d;
            drop_q      <= drop_d;
            spi_data_q  <= spi_data_d;
            spi_write_q <= spi_write_d;
            done_q      <= done_d;
            done_ok_q   <= done_ok_d;
            busy_q      <= busy_d;
            holdoff_q   <= holdoff_d;
        end
    end

    assign spi_data   = spi_data_q;
    assign spi_write  = spi_write_q;
    assign done       = done_q;
    assign done_ok    = done_ok_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule
